// File: rtl/dac_stream_out_if.sv
// Sample handshake between the sample generator and the DAC output stage.
//   s_valid : producer has a sample on s_data
//   s_ready : consumer can accept a sample this cycle
//   s_data  : unsigned offset-binary sample
interface dac_stream_out_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/dac_stream_out.sv
// Output stage driving an 8-bit parallel DAC. Samples arrive over a valid/ready
// handshake into a small FIFO. DAC_CLK is CLK divided by 2*DIV; one sample is
// popped per DAC_CLK period and DAC changes only as DAC_CLK falls, so the data
// is stable at the converter's rising-edge capture. An empty update slot holds
// DAC and sets a sticky underrun flag.
//   CLK, RESET      : system clock, synchronous active-high reset
//   s (slave)       : s_valid / s_ready / s_data sample handshake
//   enable          : run DAC_CLK and consume samples; freezes phase when low
//   clear_underrun  : one-cycle pulse clearing underrun (an empty slot wins)
//   DAC_CLK, DAC    : registered converter clock and data
//   underrun        : sticky empty-slot flag
//   level           : FIFO occupancy, 0..DEPTH
module dac_stream_out #(
  parameter int unsigned DIV       = 4,
  parameter int unsigned DEPTH     = 4,
  parameter logic [7:0]  IDLE_CODE = 8'h80
) (
  input  logic                   CLK,
  input  logic                   RESET,
  dac_stream_out_if.slave        s,
  input  logic                   enable,
  input  logic                   clear_underrun,
  output logic                   DAC_CLK,
  output logic [7:0]             DAC,
  output logic                   underrun,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(2 * DIV);

  localparam logic [CW-1:0] CntRise = CW'(DIV - 1);
  localparam logic [CW-1:0] CntLast = CW'(2 * DIV - 1);
  localparam logic [AW:0]   LvlFull = (AW + 1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q, level_d;
  logic          ready_q;
  logic [CW-1:0] cnt_q;
  logic          dac_clk_q;
  logic [7:0]    dac_q;
  logic          underrun_q;

  logic push, slot, pop;

  always_comb begin
    push    = s.s_valid & ready_q;
    slot    = enable & (cnt_q == CntLast);
    pop     = slot & (level_q != '0);
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ready_q    <= 1'b0;
      cnt_q      <= '0;
      dac_clk_q  <= 1'b0;
      dac_q      <= IDLE_CODE;
      underrun_q <= 1'b0;
    end else begin
      level_q <= level_d;
      // Registered from next-state level: ready stays low through reset and
      // a pop while full only frees a slot from the following cycle.
      ready_q <= (level_d != LvlFull);
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        dac_q    <= mem_q[rd_ptr_q];
      end
      if (enable) begin
        if (cnt_q == CntLast) begin
          cnt_q     <= '0;
          dac_clk_q <= 1'b0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntRise) dac_clk_q <= 1'b1;
        end
      end
      // An empty slot takes priority over a simultaneous clear.
      if (slot && !pop) begin
        underrun_q <= 1'b1;
      end else if (clear_underrun) begin
        underrun_q <= 1'b0;
      end
    end
  end

  // Storage needs no reset; pointers and level define validity.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= s.s_data;
  end

  assign s.s_ready = ready_q;
  assign DAC_CLK   = dac_clk_q;
  assign DAC       = dac_q;
  assign underrun  = underrun_q;
  assign level     = level_q;

endmodule

// File: tb/tb_dac_stream_out.sv
module tb_dac_stream_out;
  localparam int DIV = 4;
  localparam int DEPTH = 4;
  localparam logic [7:0] IDLE = 8'h80;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       enable = 1'b0;
  logic       clear_underrun = 1'b0;
  logic       DAC_CLK;
  logic [7:0] DAC;
  logic       underrun;
  logic [2:0] level;

  dac_stream_out_if bus ();

  dac_stream_out #(.DIV(DIV), .DEPTH(DEPTH), .IDLE_CODE(IDLE)) dut (
    .CLK(CLK), .RESET(RESET), .s(bus.slave), .enable(enable),
    .clear_underrun(clear_underrun), .DAC_CLK(DAC_CLK), .DAC(DAC),
    .underrun(underrun), .level(level)
  );

  always #5 CLK = ~CLK;

  int edge_n = 0;
  always @(posedge CLK) edge_n <= edge_n + 1;

  typedef struct {
    int         idx;
    logic       rst;
    logic       dclk;
    logic [7:0] dac;
    logic       und;
    int         lvl;
    logic       rdy;
  } cyc_t;

  typedef struct {
    int         idx;
    logic [7:0] dac;
    logic       und;
  } slot_t;

  cyc_t  cyc_q[$];
  slot_t slot_q[$];

  // Reference model: sample queue, count of enabled cycles modulo one DAC_CLK
  // period, and the values the outputs should carry.
  logic [7:0] m_fifo[$];
  int         m_ph = 0;
  logic [7:0] m_dac = IDLE;
  logic       m_und = 1'b0;
  logic       m_rdy = 1'b0;
  bit         last_push = 1'b0;

  int total = 0;
  int bad = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endfunction

  // Drive one cycle of inputs and record what the following edge must yield.
  task automatic step(input logic rst, input logic v, input logic [7:0] d,
                      input logic en, input logic clr);
    cyc_t  c;
    slot_t sl;
    bit    push, slot;
    @(negedge CLK);
    RESET = rst;
    bus.s_valid = v;
    bus.s_data = d;
    enable = en;
    clear_underrun = clr;
    if (rst) begin
      m_fifo.delete();
      m_ph = 0;
      m_dac = IDLE;
      m_und = 1'b0;
      m_rdy = 1'b0;
      last_push = 1'b0;
    end else begin
      push = v && m_rdy;
      slot = en && (m_ph == 2 * DIV - 1);
      if (en) m_ph = (m_ph + 1) % (2 * DIV);
      if (slot && m_fifo.size() == 0) m_und = 1'b1;
      else if (clr) m_und = 1'b0;
      if (slot && m_fifo.size() > 0) m_dac = m_fifo.pop_front();
      if (push) m_fifo.push_back(d);
      m_rdy = (m_fifo.size() != DEPTH);
      last_push = push;
      if (slot) begin
        sl.idx = edge_n + 1;
        sl.dac = m_dac;
        sl.und = m_und;
        slot_q.push_back(sl);
      end
    end
    c.idx = edge_n + 1;
    c.rst = rst;
    c.dclk = (m_ph >= DIV);
    c.dac = m_dac;
    c.und = m_und;
    c.lvl = m_fifo.size();
    c.rdy = m_rdy;
    cyc_q.push_back(c);
  endtask

  // Monitor: per-cycle state check plus scoreboard pop on each DAC_CLK fall.
  initial begin
    cyc_t  c;
    slot_t sl;
    logic  prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (cyc_q.size() > 0 && cyc_q[0].idx <= edge_n) begin
        c = cyc_q.pop_front();
        chk("dac_clk", 32'(DAC_CLK), 32'(c.dclk));
        chk("dac", 32'(DAC), 32'(c.dac));
        chk("underrun", 32'(underrun), 32'(c.und));
        chk("level", 32'(level), 32'(c.lvl));
        chk("s_ready", 32'(bus.s_ready), 32'(c.rdy));
        if (prev === 1'b1 && DAC_CLK === 1'b0 && !c.rst) begin
          if (slot_q.size() > 0 && slot_q[0].idx == edge_n) begin
            sl = slot_q.pop_front();
            chk("slot_dac", 32'(DAC), 32'(sl.dac));
            chk("slot_underrun", 32'(underrun), 32'(sl.und));
          end else begin
            total++;
            bad++;
            $display("FAIL slot_unexpected: DAC_CLK fell at edge %0d, no update slot due",
                     edge_n);
          end
        end
      end
      prev = DAC_CLK;
    end
  end

  initial begin
    int cur;
    bus.s_valid = 1'b1;
    bus.s_data = 8'h00;

    // Reset held three cycles with valid and enable high.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'($urandom), 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Single sample: push, then run; DAC_CLK rises at 4, falls with data at 8.
    step(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    m_und = m_und;  // underrun is set by the empty slots above
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 8'h00, 1'b0, (i == 0));

    // Backpressure: fill while disabled, then drain in order.
    cur = 1;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 8'(cur), 1'b0, 1'b0);
      if (last_push) cur++;
    end
    for (int i = 0; i < 80 && cur <= 6; i++) begin
      step(1'b0, 1'b1, 8'(cur), 1'b1, 1'b0);
      if (last_push) cur++;
    end
    for (int i = 0; i < 6 * 2 * DIV; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Underrun: one sample, then empty slots; clear off-slot and on a slot.
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);
    for (int i = 0; i < 48; i++)
      step(1'b0, 1'b0, 8'h00, 1'b1, (i == 27) || (i > 34 && m_ph == 2 * DIV - 1));

    // Enable gap at cnt = 5 with DAC_CLK high.
    step(1'b0, 1'b1, 8'hC3, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
    for (int i = 0; i < 16 && m_ph != 5; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Reset mid-stream with level 3 and DAC_CLK high.
    for (int i = 0; i < 3 * 2 * DIV; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 16 && m_ph != 5; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 1'b1, 8'hA1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'hA2, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'hA3, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'hA4, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b0, (i % 3 == 0), 8'(8'h10 + i), 1'b1, 1'b0);

    // Randomized traffic with occasional clears and resets.
    for (int i = 0; i < 1500; i++)
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 4), 8'($urandom),
           ($urandom_range(0, 9) != 0), ($urandom_range(0, 29) == 0));

    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    chk("slot_leftover", 32'(slot_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
